// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 encryptor with a 24-bit key.
//
// On an accepted start this block performs four steps:
//   1. It fills the external 256x8 S memory with the identity permutation (INIT).
//   2. It runs the key schedule over S (KSA).
//   3. It reads the length byte L from pt[0] and copies it to ct[0] (LEN).
//   4. For k = 1..L it generates one keystream byte and writes ct[k] = pad ^ pt[k] (PRGA).
// All three memories are synchronous with a 1-cycle read latency. Every read state therefore
// presents an address, and the state after it consumes the data.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   en / rdy            start request / idle indication; key is sampled on the accepted en
//   key[23:0]           key bytes key[23:16], key[15:8], key[7:0] for i mod 3 = 0, 1, 2
//   pt_addr, pt_rddata  plaintext read port (length-prefixed message)
//   ct_addr, ct_wrdata, ct_wren     ciphertext write port
//   s_addr, s_wrdata, s_wren, s_rddata  S memory port
//   pt_printable        only when ARC4_ENC_PRINTABLE_CHECK_EN is defined. It is cleared
//                       (sticky) when any pt[k], k >= 1, falls outside 0x20..0x7E.
//
// Optional feature macro: ARC4_ENC_PRINTABLE_CHECK_EN.
//
// Cycle budget per message: INIT 256 + KSA 1536 + LEN 4 + PRGA 11*L + DONE 1.

module arc4_encrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
  output logic        pt_printable,
`endif
  input  logic [7:0]  s_rddata
);

  typedef enum logic [4:0] {
    StIdle,
    StInit,
    StKsaRdSi,
    StKsaWtSi,
    StKsaRdSj,
    StKsaWtSj,
    StKsaWrSi,
    StKsaWrSj,
    StLenRd,
    StLenWt,
    StLenWr,
    StLenClr,
    StPrgaInc,
    StPrgaRdSi,
    StPrgaWtSi,
    StPrgaRdSj,
    StPrgaWtSj,
    StPrgaWrSi,
    StPrgaWrSj,
    StPrgaRdPad,
    StPrgaWtPad,
    StPrgaRdPt,
    StPrgaWrCt,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] key_q, key_d;
  // i doubles as the fill counter during INIT.
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  k_q, k_d;
  // Key byte selector, tracks i mod 3 during KSA.
  logic [1:0]  kb_q, kb_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  pad_q, pad_d;

  logic [7:0]  key_byte;
  logic [7:0]  pad_idx;

  always_comb begin
    key_byte = key_q[7:0];
    unique case (kb_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  // Sum is naturally modulo 256 in 8 bits.
  assign pad_idx = si_q + sj_q;

`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
  logic printable_q, printable_d;
  assign pt_printable = printable_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      kb_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      len_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kb_q    <= kb_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      len_q   <= len_d;
      pad_q   <= pad_d;
    end
  end

`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      printable_q <= 1'b1;
    end else begin
      printable_q <= printable_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    kb_d      = kb_q;
    si_d      = si_q;
    sj_d      = sj_q;
    len_d     = len_q;
    pad_d     = pad_q;
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    printable_d = printable_q;
`endif
    rdy       = 1'b0;
    pt_addr   = 8'd0;
    ct_addr   = 8'd0;
    ct_wrdata = 8'd0;
    ct_wren   = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;

    unique case (state_q)
      StIdle: begin
        rdy = 1'b1;
        if (en) begin
          key_d   = key;
          i_d     = 8'd0;
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
          printable_d = 1'b1;
`endif
          state_d = StInit;
        end
      end

      StInit: begin
        s_wren   = 1'b1;
        s_addr   = i_q;
        s_wrdata = i_q;
        i_d      = i_q + 8'd1;
        // i wraps back to 0, which is exactly the first KSA index.
        if (i_q == 8'hFF) begin
          j_d     = 8'd0;
          kb_d    = 2'd0;
          state_d = StKsaRdSi;
        end
      end

      // ---------------- KSA: 6 cycles per i ----------------
      StKsaRdSi: begin
        s_addr  = i_q;
        state_d = StKsaWtSi;
      end

      StKsaWtSi: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + key_byte;
        state_d = StKsaRdSj;
      end

      StKsaRdSj: begin
        s_addr  = j_q;
        state_d = StKsaWtSj;
      end

      StKsaWtSj: begin
        sj_d    = s_rddata;
        state_d = StKsaWrSi;
      end

      StKsaWrSi: begin
        s_wren   = 1'b1;
        s_addr   = i_q;
        s_wrdata = sj_q;
        state_d  = StKsaWrSj;
      end

      StKsaWrSj: begin
        // When i == j this rewrites the same byte with its original value, which is correct.
        s_wren   = 1'b1;
        s_addr   = j_q;
        s_wrdata = si_q;
        i_d      = i_q + 8'd1;
        kb_d     = (kb_q == 2'd2) ? 2'd0 : kb_q + 2'd1;
        state_d  = (i_q == 8'hFF) ? StLenRd : StKsaRdSi;
      end

      // ---------------- LEN: 4 cycles ----------------
      StLenRd: begin
        pt_addr = 8'd0;
        state_d = StLenWt;
      end

      StLenWt: begin
        len_d   = pt_rddata;
        state_d = StLenWr;
      end

      StLenWr: begin
        ct_wren   = 1'b1;
        ct_addr   = 8'd0;
        ct_wrdata = len_q;
        state_d   = StLenClr;
      end

      StLenClr: begin
        i_d     = 8'd0;
        j_d     = 8'd0;
        k_d     = 8'd1;
        state_d = (len_q == 8'd0) ? StDone : StPrgaInc;
      end

      // ---------------- PRGA: 11 cycles per byte ----------------
      StPrgaInc: begin
        i_d     = i_q + 8'd1;
        state_d = StPrgaRdSi;
      end

      StPrgaRdSi: begin
        s_addr  = i_q;
        state_d = StPrgaWtSi;
      end

      StPrgaWtSi: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = StPrgaRdSj;
      end

      StPrgaRdSj: begin
        s_addr  = j_q;
        state_d = StPrgaWtSj;
      end

      StPrgaWtSj: begin
        sj_d    = s_rddata;
        state_d = StPrgaWrSi;
      end

      StPrgaWrSi: begin
        s_wren   = 1'b1;
        s_addr   = i_q;
        s_wrdata = sj_q;
        state_d  = StPrgaWrSj;
      end

      StPrgaWrSj: begin
        s_wren   = 1'b1;
        s_addr   = j_q;
        s_wrdata = si_q;
        state_d  = StPrgaRdPad;
      end

      StPrgaRdPad: begin
        // si/sj still hold the pre-swap values, so their sum is the PRGA pad index.
        s_addr  = pad_idx;
        state_d = StPrgaWtPad;
      end

      StPrgaWtPad: begin
        pad_d   = s_rddata;
        state_d = StPrgaRdPt;
      end

      StPrgaRdPt: begin
        pt_addr = k_q;
        state_d = StPrgaWrCt;
      end

      StPrgaWrCt: begin
        // pt_rddata now holds pt[k], read in the previous state.
        ct_wren   = 1'b1;
        ct_addr   = k_q;
        ct_wrdata = pad_q ^ pt_rddata;
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
        if (pt_rddata < 8'h20 || pt_rddata > 8'h7E) begin
          printable_d = 1'b0;
        end
`endif
        k_d       = k_q + 8'd1;
        // Compare before incrementing so that L = 255 ends without k wrapping.
        state_d   = (k_q == len_q) ? StDone : StPrgaInc;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
`timescale 1ns/1ps
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key = 24'h0;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;
  logic [7:0]  s_addr, s_wrdata, s_rddata;
  logic        s_wren;
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
  logic        pt_printable;
`endif

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren),
    .s_addr    (s_addr),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    .pt_printable (pt_printable),
`endif
    .s_rddata  (s_rddata)
  );

  // Synchronous memories, 1-cycle read latency.
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_mem  [256];
  logic       mem_clr = 1'b0;
  int         ct_wr_cnt = 0;
  int         s_wr_cnt = 0;
  logic [7:0] last_ct_addr = 8'h0;

  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    s_rddata  <= s_mem[s_addr];
    if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
      s_wr_cnt      <= s_wr_cnt + 1;
    end
    if (mem_clr) begin
      for (int a = 0; a < 256; a++) ct_mem[a] <= 8'hEE;
    end else if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      ct_wr_cnt       <= ct_wr_cnt + 1;
      last_ct_addr    <= ct_addr;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] key;
    int unsigned len;
    logic [79:0] pt;   // byte b at [8*b +: 8]; byte 0 is the length
    logic [79:0] ct;
    int unsigned cycles;
    bit          printable;
  } vec_t;

  vec_t vecs[3];

  task automatic load_pt(input logic [79:0] bytes, input int unsigned n);
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h41;
    for (int b = 0; b < 10; b++) begin
      if (b < int'(n)) pt_mem[b] = bytes[8*b +: 8];
    end
  endtask

  task automatic clear_ct();
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
  endtask

  // Called #1 after a posedge while idle. Returns the number of busy cycles.
  task automatic run_msg(input logic [23:0] k, input bit inject, output int unsigned cyc);
    int unsigned cnt;
    key = k;
    en  = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
    check("rdy_falls", 32'(rdy), 32'd0);
    cnt = 0;
    while (!rdy && cnt < 6000) begin
      @(posedge clk); #1;
      cnt++;
      if (inject && cnt == 100) begin
        key = 24'h123456;
        en  = 1'b1;
      end
      if (inject && cnt == 101) en = 1'b0;
    end
    cyc = cnt;
  endtask

  task automatic check_run(input vec_t v, input string tag, input bit inject);
    int unsigned cyc;
    int          w0;
    load_pt(v.pt, (v.len < 9) ? v.len + 1 : 10);
    clear_ct();
    w0 = ct_wr_cnt;
    run_msg(v.key, inject, cyc);
    check({tag, "_cycles"}, cyc, v.cycles);
    check({tag, "_ct_writes"}, ct_wr_cnt - w0, v.len + 1);
    check({tag, "_last_addr"}, 32'(last_ct_addr), v.len);
    for (int b = 0; b <= int'(v.len) && b < 10; b++) begin
      check($sformatf("%s_ct%0d", tag, b), 32'(ct_mem[b]), 32'(v.ct[8*b +: 8]));
    end
    if (v.len < 255) check({tag, "_no_extra"}, 32'(ct_mem[v.len + 1]), 32'hEE);
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    check({tag, "_printable"}, 32'(pt_printable), 32'(v.printable));
`endif
  endtask

  initial begin
    int unsigned cyc;
    int          w0;
    vec_t        big;

    vecs[0] = '{key: 24'h4B6579, len: 9,
                pt: {8'h74, 8'h78, 8'h65, 8'h74, 8'h6E, 8'h69, 8'h61, 8'h6C, 8'h50, 8'h09},
                ct: {8'hD3, 8'h0A, 8'hAF, 8'h40, 8'hD9, 8'hE8, 8'h16, 8'hF3, 8'hBB, 8'h09},
                cycles: 1896, printable: 1'b1};
    vecs[1] = '{key: 24'h4B6579, len: 0, pt: 80'h0, ct: 80'h0,
                cycles: 1797, printable: 1'b1};
    // Keystream bytes EB, 9F (from the known vector) XOR 41, 0A.
    vecs[2] = '{key: 24'h4B6579, len: 2, pt: {56'h0, 8'h0A, 8'h41, 8'h02},
                ct: {56'h0, 8'h95, 8'hAA, 8'h02}, cycles: 1819, printable: 1'b0};

    for (int a = 0; a < 256; a++) s_mem[a] = 8'h00;
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_ct_wren", 32'(ct_wren), 32'd0);
    check("rst_s_wren", 32'(s_wren), 32'd0);
    check("rst_pt_addr", 32'(pt_addr), 32'd0);
    check("rst_ct_addr", 32'(ct_addr), 32'd0);
    check("rst_s_addr", 32'(s_addr), 32'd0);
    check("rst_ct_wrdata", 32'(ct_wrdata), 32'd0);
    check("rst_s_wrdata", 32'(s_wrdata), 32'd0);
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    check("rst_printable", 32'(pt_printable), 32'd1);
`endif

    // Table-driven messages.
    for (int v = 0; v < 3; v++) check_run(vecs[v], $sformatf("vec%0d", v), 1'b0);

    // en while busy with a different key must be ignored.
    check_run(vecs[0], "ignore_en", 1'b1);

    // Asynchronous reset during KSA.
    load_pt(vecs[0].pt, 10);
    key = 24'h4B6579;
    en  = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
    repeat (400) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_s_wren", 32'(s_wren), 32'd0);
    check("midrst_s_addr", 32'(s_addr), 32'd0);
    check("midrst_ct_wren", 32'(ct_wren), 32'd0);
    w0 = s_wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_s_writes", s_wr_cnt - w0, 32'd0);
    check("midrst_rdy_after", 32'(rdy), 32'd1);
    check_run(vecs[0], "after_rst", 1'b0);

    // L = 255: index must stop at 255 without wrapping; the first 9 bytes are the known vector.
    big = vecs[0];
    big.len = 255;
    big.pt[7:0] = 8'hFF;
    big.ct[7:0] = 8'hFF;
    big.cycles = 1797 + 11 * 255;
    check_run(big, "len255", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
